// File: rtl/sm2201_xcvr_pkg.sv
// Shared state encoding, default sizing and next-state rule for the bus transceiver.
// SM2201_XCVR_PARITY_EN adds one even-parity bit to the bus.
package sm2201_xcvr_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_TX   = 2'd1,
        ST_RX   = 2'd2,
        ST_TURN = 2'd3
    } xcvr_state_e;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_TURN_CYC = 2;

`ifdef SM2201_XCVR_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // TURN exits on the live dce, not on the direction that caused the reversal.
    function automatic xcvr_state_e next_state(input xcvr_state_e cur,
                                               input logic cs_n,
                                               input logic dce,
                                               input logic turn_done,
                                               input logic direct);
        next_state = cur;
        if (cs_n) begin
            next_state = ST_OFF;
        end else begin
            case (cur)
                ST_OFF:  next_state = dce ? ST_RX : ST_TX;
                ST_TX:   if (dce)  next_state = direct ? ST_RX : ST_TURN;
                ST_RX:   if (!dce) next_state = direct ? ST_TX : ST_TURN;
                ST_TURN: if (turn_done) next_state = dce ? ST_RX : ST_TX;
                default: next_state = ST_OFF;
            endcase
        end
    endfunction

endpackage

// File: rtl/sm2201_turn_timer.sv
// Turnaround down-counter: loads on TURN entry, counts to zero, flags terminal count.
module sm2201_turn_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sm2201_bus_xcvr.sv
// Half-duplex bus transceiver with dead-cycle turnaround between TX and RX.
// SM2201_XCVR_PARITY_EN widens the bus by one even-parity bit and enables par_err.
//
// state   | meaning
// OFF     | deselected, bus released
// TX      | driving registered d_in onto d_bus
// RX      | sampling d_bus into d_out
// TURN    | dead cycles between directions, bus released
module sm2201_bus_xcvr
    import sm2201_xcvr_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TURN_CYC = DEF_TURN_CYC,
    localparam int BW      = WIDTH + PAR_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             dce,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    inout  wire logic [BW-1:0] d_bus,
    output logic             bus_oe,
    output logic             rx_valid,
    output logic             busy,
    output logic             par_err
);

    localparam int CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
    localparam logic [CW-1:0] TURN_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic DIRECT = (TURN_CYC == 0);

    xcvr_state_e      state;
    xcvr_state_e      nxt;
    logic [WIDTH-1:0] tx_q;
    logic             turn_zero;
    logic             capture;
    logic             tx_entry;

    assign nxt      = next_state(state, cs_n, dce, turn_zero, DIRECT);
    // Capture only while staying in RX so d_out and rx_valid are quiet in every other state.
    assign capture  = (state == ST_RX) && (nxt == ST_RX);
    assign tx_entry = (state != ST_TX) && (nxt == ST_TX);

    sm2201_turn_timer #(.CW(CW)) u_turn_timer (
        .clk      (clk),
        .rst      (rst),
        .load     ((state != ST_TURN) && (nxt == ST_TURN)),
        .dec      (state == ST_TURN),
        .load_val (TURN_LOAD),
        .zero     (turn_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            bus_oe   <= 1'b0;
            tx_q     <= '0;
            d_out    <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt;
            bus_oe   <= (nxt == ST_TX);
            busy     <= (nxt == ST_TURN);
            rx_valid <= capture;
            if (nxt == ST_TX) tx_q  <= d_in;
            if (capture)      d_out <= d_bus[WIDTH-1:0];
        end
    end

`ifdef SM2201_XCVR_PARITY_EN
    logic par_q;
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (nxt == ST_TX) par_q <= ^d_in;
            if (tx_entry) begin
                par_err_q <= 1'b0;
            end else if (capture && (^d_bus)) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err = par_err_q;
    assign d_bus   = bus_oe ? {par_q, tx_q} : {BW{1'bz}};
`else
    logic unused_tx_entry;
    assign unused_tx_entry = tx_entry;
    assign par_err = 1'b0;
    assign d_bus   = bus_oe ? tx_q : {BW{1'bz}};
`endif

endmodule
